// File: rtl/panel_input.sv
// panel_input: pushbutton front end for the DDS control panel.
// Synchronizes and debounces the five Nexys buttons, then maintains the
// frequency and amplitude setpoints. Steps are saturated rather than wrapped,
// and U/D auto-repeat when held.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   btn_u/btn_d/btn_l/btn_r/btn_c   raw buttons: inc, dec, idx down, idx up,
//                                   toggle field
//   freq      [15:0]                frequency setpoint in Hz
//   amp       [7:0]                 amplitude setpoint, 0..AMP_MAX
//   edit_amp                        0 = U/D edit freq, 1 = U/D edit amp
//   step_idx  [1:0]                 step size index, 0..2
//   update                          one-cycle pulse after freq/amp changed value
module panel_input #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000,
  parameter int FREQ_MIN        = 100,
  parameter int FREQ_MAX        = 20000,
  parameter int FREQ_DEFAULT    = 1000,
  parameter int AMP_MAX         = 99,
  parameter int AMP_DEFAULT     = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_u,
  input  logic        btn_d,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic        btn_c,
  output logic [15:0] freq,
  output logic [7:0]  amp,
  output logic        edit_amp,
  output logic [1:0]  step_idx,
  output logic        update
);
  localparam int NB  = 5;
  localparam int B_U = 0;
  localparam int B_D = 1;
  localparam int B_L = 2;
  localparam int B_R = 3;
  localparam int B_C = 4;
  localparam int DCW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = $clog2(RMAX + 1);
  localparam logic [DCW-1:0] DB_LAST    = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0]  DELAY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0]  RATE_LAST  = TW'(REPEAT_RATE - 1);
  localparam logic signed [16:0] F_MIN_S = 17'(FREQ_MIN);
  localparam logic signed [16:0] F_MAX_S = 17'(FREQ_MAX);
  localparam logic signed [8:0]  A_MAX_S = 9'(AMP_MAX);

  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REPEAT} state_t;

  function automatic logic [15:0] sat_freq(input logic signed [16:0] v);
    if (v > F_MAX_S)      return F_MAX_S[15:0];
    else if (v < F_MIN_S) return F_MIN_S[15:0];
    else                  return v[15:0];
  endfunction

  function automatic logic [7:0] sat_amp(input logic signed [8:0] v);
    if (v > A_MAX_S)      return A_MAX_S[7:0];
    else if (v < 9'sd0)   return 8'd0;
    else                  return v[7:0];
  endfunction

  logic [NB-1:0]  raw, sync_p0, sync_p1, stable;
  logic [DCW-1:0] db_cnt [NB];
  logic [2:0]     lrc_q;
  logic           rise_l, rise_r, rise_c;

  dir_t            dir, held, held_nxt;
  state_t          state, state_nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic            step_go;
  logic signed [16:0] freq_w, fstep, freq_calc;
  logic signed [8:0]  amp_w, astep, amp_calc;
  logic [15:0]     freq_nxt;
  logic [7:0]      amp_nxt;

  assign raw = {btn_c, btn_r, btn_l, btn_d, btn_u};

  // Stage p0/p1: two-flop synchronizer, then per-button debounce and edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      stable  <= '0;
      lrc_q   <= '0;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      lrc_q   <= {stable[B_C], stable[B_R], stable[B_L]};
      for (int i = 0; i < NB; i++) begin
        if (sync_p1[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= sync_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise_l = stable[B_L] & ~lrc_q[0];
  assign rise_r = stable[B_R] & ~lrc_q[1];
  assign rise_c = stable[B_C] & ~lrc_q[2];

  always_comb begin
    dir = DIR_NONE;
    if (stable[B_U] && !stable[B_D])      dir = DIR_UP;
    else if (stable[B_D] && !stable[B_U]) dir = DIR_DN;
  end

  // Hold/auto-repeat sequencer; any change of direction drops back to IDLE,
  // so a reversal always restarts with a single step and the full delay.
  always_comb begin
    state_nxt = state;
    held_nxt  = held;
    timer_nxt = timer;
    step_go   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (dir != DIR_NONE) begin
          step_go   = 1'b1;
          timer_nxt = '0;
          held_nxt  = dir;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dir != held) begin
          state_nxt = S_IDLE;
          timer_nxt = '0;
        end else if (timer == DELAY_LAST) begin
          step_go   = 1'b1;
          timer_nxt = '0;
          state_nxt = S_REPEAT;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      S_REPEAT: begin
        if (dir != held) begin
          state_nxt = S_IDLE;
          timer_nxt = '0;
        end else if (timer == RATE_LAST) begin
          step_go   = 1'b1;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Step uses the current (pre-edge) field and index, so a same-cycle C/L/R
  // edge only affects later steps.
  always_comb begin
    freq_w = signed'({1'b0, freq});
    amp_w  = signed'({1'b0, amp});
    unique case (step_idx)
      2'd0:    begin fstep = 17'sd10;   astep = 9'sd1;  end
      2'd1:    begin fstep = 17'sd100;  astep = 9'sd5;  end
      default: begin fstep = 17'sd1000; astep = 9'sd10; end
    endcase
    freq_calc = (dir == DIR_UP) ? freq_w + fstep : freq_w - fstep;
    amp_calc  = (dir == DIR_UP) ? amp_w + astep  : amp_w - astep;
    freq_nxt  = freq;
    amp_nxt   = amp;
    if (step_go) begin
      if (edit_amp) amp_nxt  = sat_amp(amp_calc);
      else          freq_nxt = sat_freq(freq_calc);
    end
  end

  // Stage p2: setpoint, field/index and sequencer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      held     <= DIR_NONE;
      timer    <= '0;
      freq     <= 16'(FREQ_DEFAULT);
      amp      <= 8'(AMP_DEFAULT);
      edit_amp <= 1'b0;
      step_idx <= 2'd0;
      update   <= 1'b0;
    end else begin
      state    <= state_nxt;
      held     <= held_nxt;
      timer    <= timer_nxt;
      freq     <= freq_nxt;
      amp      <= amp_nxt;
      update   <= (freq_nxt != freq) || (amp_nxt != amp);
      if (rise_c) edit_amp <= ~edit_amp;
      if (rise_r && step_idx != 2'd2)      step_idx <= step_idx + 2'd1;
      else if (rise_l && step_idx != 2'd0) step_idx <= step_idx - 2'd1;
    end
  end
endmodule

// File: tb/tb_panel_input.sv
module tb_panel_input;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0, btn_c = 1'b0;
  logic [15:0] freq;
  logic [7:0]  amp;
  logic        edit_amp;
  logic [1:0]  step_idx;
  logic        update;

  int tests = 0;
  int fails = 0;
  int n_upd = 0;

  typedef struct {int f; int a;} exp_t;
  exp_t sb_q[$];

  int m_freq = 1000, m_amp = 50, m_idx = 0;
  bit m_edit = 1'b0;

  always #5 clk = ~clk;

  panel_input #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(5)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r), .btn_c(btn_c),
    .freq(freq), .amp(amp), .edit_amp(edit_amp), .step_idx(step_idx), .update(update)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_freq = 1000; m_amp = 50; m_edit = 1'b0; m_idx = 0;
    sb_q.delete();
  endtask

  task automatic model_step(input bit up);
    int s, n;
    if (!m_edit) begin
      s = (m_idx == 0) ? 10 : (m_idx == 1) ? 100 : 1000;
      n = up ? m_freq + s : m_freq - s;
      if (n > 20000) n = 20000;
      if (n < 100)   n = 100;
      if (n != m_freq) sb_q.push_back('{n, m_amp});
      m_freq = n;
    end else begin
      s = (m_idx == 0) ? 1 : (m_idx == 1) ? 5 : 10;
      n = up ? m_amp + s : m_amp - s;
      if (n > 99) n = 99;
      if (n < 0)  n = 0;
      if (n != m_amp) sb_q.push_back('{m_freq, n});
      m_amp = n;
    end
  endtask

  task automatic check_defaults(input string tag);
    chk({tag, "_freq"}, 32'(freq), 32'd1000);
    chk({tag, "_amp"}, 32'(amp), 32'd50);
    chk({tag, "_edit"}, 32'(edit_amp), 32'd0);
    chk({tag, "_idx"}, 32'(step_idx), 32'd0);
    chk({tag, "_upd"}, 32'(update), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btn_u = 0; btn_d = 0; btn_l = 0; btn_r = 0; btn_c = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check_defaults("reset");
  endtask

  // Scoreboard: each update pulse must match the oldest expected setpoint.
  always @(negedge clk) begin : mon
    exp_t e;
    if (update === 1'b1) begin
      n_upd++;
      chk("upd_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("upd_freq", 32'(freq), 32'(e.f));
        chk("upd_amp", 32'(amp), 32'(e.a));
      end
    end
  end

  // Press U or D, release rel cycles after the raw edge; optionally assert
  // reset asynchronously at cycle abort_k. Steps land 7 cycles after the
  // raw edge, 20 later, then every 5 while the debounced level is still held.
  task automatic hold_ud(input bit up, input int rel, input int abort_k);
    int last;
    last = rel + 12;
    @(posedge clk); #1;
    if (up) btn_u = 1'b1; else btn_d = 1'b1;
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      if (k == rel) begin btn_u = 1'b0; btn_d = 1'b0; end
      if (k == 7 || (k >= 27 && (k - 27) % 5 == 0 && k <= rel + 6)) model_step(up);
      if (k == abort_k) begin
        #2 rst_n = 1'b0;
        #1 check_defaults("mid_rst");
        btn_u = 1'b0; btn_d = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        k = last;
      end else begin
        @(negedge clk);
        chk("hold_freq", 32'(freq), 32'(m_freq));
        chk("hold_amp", 32'(amp), 32'(m_amp));
      end
    end
  endtask

  task automatic tap(input int which);
    @(posedge clk); #1;
    case (which)
      2: btn_l = 1'b1;
      3: btn_r = 1'b1;
      default: btn_c = 1'b1;
    endcase
    repeat (12) @(posedge clk);
    #1 btn_l = 1'b0; btn_r = 1'b0; btn_c = 1'b0;
    repeat (12) @(posedge clk);
    case (which)
      2: if (m_idx > 0) m_idx--;
      3: if (m_idx < 2) m_idx++;
      default: m_edit = !m_edit;
    endcase
    @(negedge clk);
    chk("tap_edit", 32'(edit_amp), 32'(m_edit));
    chk("tap_idx", 32'(step_idx), 32'(m_idx));
    chk("tap_freq", 32'(freq), 32'(m_freq));
    chk("tap_amp", 32'(amp), 32'(m_amp));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset
    do_reset();

    // Bounce rejection: 2-cycle pulses never survive the debouncer
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 btn_u = ~btn_u;
      @(posedge clk);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("bounce_freq", 32'(freq), 32'd1000);
    end
    chk("bounce_upd_cnt", 32'(n_upd), 32'd0);

    // Clean press: step exactly 7 cycles after the raw edge
    hold_ud(1'b1, 10, 0);
    chk("press_freq", 32'(freq), 32'd1010);
    chk("press_upd_cnt", 32'(n_upd), 32'd1);

    // Auto-repeat for 60 cycles after the first step, then release
    hold_ud(1'b1, 67, 0);
    chk("repeat_freq", 32'(freq), 32'd1120);

    // Reset asserted while repeating
    hold_ud(1'b1, 200, 40);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_freq", 32'(freq), 32'd1000);
    end

    // Upper frequency saturation
    tap(3); tap(3);
    tap(3);
    chk("idx_max", 32'(step_idx), 32'd2);
    hold_ud(1'b1, 101, 0);
    tap(2);
    hold_ud(1'b1, 36, 0);
    chk("freq_19500", 32'(freq), 32'd19500);
    tap(3);
    hold_ud(1'b1, 10, 0);
    chk("freq_sat1", 32'(freq), 32'd20000);
    hold_ud(1'b1, 10, 0);
    chk("freq_sat2", 32'(freq), 32'd20000);

    // Lower frequency saturation
    do_reset();
    tap(3);
    hold_ud(1'b0, 51, 0);
    tap(2);
    hold_ud(1'b0, 36, 0);
    chk("freq_150", 32'(freq), 32'd150);
    for (int i = 0; i < 6; i++) hold_ud(1'b0, 10, 0);
    chk("freq_min", 32'(freq), 32'd100);

    // Amplitude field
    tap(4);
    chk("edit_amp", 32'(edit_amp), 32'd1);
    hold_ud(1'b0, 246, 0);
    chk("amp_3", 32'(amp), 32'd3);
    tap(3);
    hold_ud(1'b0, 10, 0);
    chk("amp_zero", 32'(amp), 32'd0);
    tap(3);
    hold_ud(1'b1, 136, 0);
    chk("amp_max", 32'(amp), 32'd99);
    tap(2); tap(2); tap(2);
    chk("idx_min", 32'(step_idx), 32'd0);

    // Conflict: U+D together does nothing; releasing D lets U step
    tap(4);
    @(posedge clk); #1 btn_u = 1'b1; btn_d = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("conflict_freq", 32'(freq), 32'(m_freq));
    end
    @(posedge clk); #1 btn_d = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 10) btn_u = 1'b0;
      if (k == 7) model_step(1'b1);
      @(negedge clk);
      chk("conflict_rel_freq", 32'(freq), 32'(m_freq));
    end
    chk("conflict_final", 32'(freq), 32'd110);

    repeat (5) @(negedge clk);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
